display_scan_controller: RTL



---
 rtl/display_pkg.sv | 28 ++
 rtl/scan_prescaler.sv | 31 +++
 rtl/display_scan_controller.sv | 94 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared widths, types and helpers for the seven-segment scan controller.
package display_pkg;

  localparam int DIGIT_COUNT = 4;
  localparam int DIGIT_W     = 4;
  localparam int SEL_W       = 2;
  localparam int FRAME_W     = DIGIT_COUNT * DIGIT_W;

  typedef logic [SEL_W-1:0]   digit_idx_t;
  typedef logic [DIGIT_W-1:0] nibble_t;

  function automatic nibble_t digit_at(input logic [FRAME_W-1:0] word, input digit_idx_t idx);
    return word[int'(idx)*DIGIT_W +: DIGIT_W];
  endfunction

  // Digit idx is blanked when it and every digit to its left are zero; digit 0 always shows.
  function automatic logic lead_zero_blank(input logic [FRAME_W-1:0] word,
                                           input digit_idx_t idx,
                                           input logic enable_blank);
    logic blank;
    blank = enable_blank && (idx != '0);
    for (int i = 1; i < DIGIT_COUNT; i++) begin
      if (i >= int'(idx) && word[i*DIGIT_W +: DIGIT_W] != '0) blank = 1'b0;
    end
    return blank;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1 and flags the terminal count.
module scan_prescaler #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic terminal
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  // Clear wins over the terminal count so a disable on that edge produces no advance.
  assign terminal = enable & ~clear & (count == LAST);

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan controller with frame snapshot, dead time and
// leading-zero blanking; all outputs registered from next-state values.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int DEAD_CYCLES = 2000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  blankLeadingZeros,
  input  logic [FRAME_W-1:0]    digitsIn,
  input  logic [DIGIT_COUNT-1:0] dpIn,
  output logic [SEL_W-1:0]      digitSelect,
  output logic [DIGIT_W-1:0]    digitValue,
  output logic                  dpOut,
  output logic                  blankOut,
  output logic                  scanTick
);

  localparam int DW = 21;
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

  digit_idx_t             index, index_n;
  logic [FRAME_W-1:0]     frame_digits, frame_digits_n;
  logic [DIGIT_COUNT-1:0] frame_dp, frame_dp_n;
  logic [DW-1:0]          dead_cnt, dead_n;
  logic                   en_q;
  logic                   entry;
  logic                   tc;

  // First enabled edge restarts the slot from count 0 so digit 0 gets a full slot.
  assign entry = enable & ~en_q;

  scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .clear    (~enable | entry),
    .terminal (tc)
  );

  always_comb begin
    index_n        = index;
    frame_digits_n = frame_digits;
    frame_dp_n     = frame_dp;
    dead_n         = dead_cnt;
    if (!enable) begin
      index_n        = '0;
      frame_digits_n = digitsIn;
      frame_dp_n     = dpIn;
      dead_n         = '0;
    end else begin
      if (tc) begin
        index_n = index + 1'b1;
        if (index == SEL_W'(DIGIT_COUNT - 1)) begin
          frame_digits_n = digitsIn;
          frame_dp_n     = dpIn;
        end
      end
      if (tc || entry)        dead_n = DEAD_LOAD;
      else if (dead_cnt != '0) dead_n = dead_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index        <= '0;
      frame_digits <= '0;
      frame_dp     <= '0;
      dead_cnt     <= '0;
      en_q         <= 1'b0;
      digitSelect  <= '0;
      digitValue   <= '0;
      dpOut        <= 1'b0;
      blankOut     <= 1'b1;
      scanTick     <= 1'b0;
    end else begin
      index        <= index_n;
      frame_digits <= frame_digits_n;
      frame_dp     <= frame_dp_n;
      dead_cnt     <= dead_n;
      en_q         <= enable;
      digitSelect  <= index_n;
      digitValue   <= digit_at(frame_digits_n, index_n);
      dpOut        <= frame_dp_n[index_n];
      blankOut     <= ~enable | (dead_n != '0) |
                      lead_zero_blank(frame_digits_n, index_n, blankLeadingZeros);
      scanTick     <= tc;
    end
  end

endmodule
